// File: rtl/irq_sequencer.sv
// ----------------------------------------------------------------------------
// irq_sequencer
//
// Interrupt entry sequencer for the ATtiny20 core. At an instruction boundary
// it takes a pending interrupt, stalls the core for three cycles, pushes the
// return address onto the stack low byte first, clears SREG.I, acknowledges
// the request and loads the PC with the interrupt vector. After RETI, one
// further instruction must retire before the next interrupt is taken.
//
// Parameters:
//   DATA_WIDTH    stack data width (8)
//   I_ADDR_WIDTH  program counter width (10, legal range 9..16)
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   irq_req       in   pending, enabled interrupt request
//   irq_vector    in   vector address paired with irq_req
//   insn_boundary in   last cycle of the retiring instruction
//   pc_next       in   return address (next instruction to execute)
//   reti_exec     in   retiring cycle of RETI
//   stall         out  core holds fetch and execute
//   stack_we      out  one stack write of stack_wdata
//   stack_wdata   out  byte to push
//   clear_i       out  pulse: clear SREG.I
//   pc_load       out  pulse: load PC with pc_load_addr
//   pc_load_addr  out  PC value to load
//   irq_ack       out  pulse: peripheral clears flag for ack_vector
//   ack_vector    out  vector being acknowledged
//   busy          out  sequence in progress
// ----------------------------------------------------------------------------
module irq_sequencer #(
   parameter int DATA_WIDTH   = 8,
   parameter int I_ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    irq_req,
   input  logic [I_ADDR_WIDTH-1:0] irq_vector,
   input  logic                    insn_boundary,
   input  logic [I_ADDR_WIDTH-1:0] pc_next,
   input  logic                    reti_exec,
   output logic                    stall,
   output logic                    stack_we,
   output logic [DATA_WIDTH-1:0]   stack_wdata,
   output logic                    clear_i,
   output logic                    pc_load,
   output logic [I_ADDR_WIDTH-1:0] pc_load_addr,
   output logic                    irq_ack,
   output logic [I_ADDR_WIDTH-1:0] ack_vector,
   output logic                    busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PUSH_LO = 2'd1;
   localparam logic [1:0] S_PUSH_HI = 2'd2;
   localparam logic [1:0] S_JUMP    = 2'd3;

   logic [1:0]              r_state;
   logic [1:0]              w_state_next;
   logic [I_ADDR_WIDTH-1:0] r_vec;
   logic [I_ADDR_WIDTH-1:0] r_ret;
   logic                    r_reti_block;

   logic                    w_idle;
   logic                    w_accept;
   logic [DATA_WIDTH-1:0]   w_ret_lo;
   logic [DATA_WIDTH-1:0]   w_ret_hi;

   assign w_idle = (r_state == S_IDLE);

   // reti_exec is excluded directly as well as through r_reti_block, because
   // the block flag only becomes visible one cycle after RETI retires.
   assign w_accept = w_idle & insn_boundary & irq_req & ~r_reti_block & ~reti_exec;

   // Return address split into stack bytes, upper part zero-extended.
   assign w_ret_lo = DATA_WIDTH'(r_ret[7:0]);
   assign w_ret_hi = DATA_WIDTH'(r_ret >> 8);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_next = S_PUSH_LO;
         S_PUSH_LO: w_state_next = S_PUSH_HI;
         S_PUSH_HI: w_state_next = S_JUMP;
         S_JUMP:    w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_vec        <= '0;
         r_ret        <= '0;
         r_reti_block <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_vec <= irq_vector;
            r_ret <= pc_next;
         end
         // Set wins over clear: the boundary that retires RETI itself must
         // not count as the following instruction.
         if (reti_exec) begin
            r_reti_block <= 1'b1;
         end else if (w_idle && insn_boundary) begin
            r_reti_block <= 1'b0;
         end
      end
   end

   // Outputs decode from registered state only, so input glitches cannot
   // reach the pulse outputs and a reset clears them immediately.
   always_comb begin
      stall        = 1'b0;
      stack_we     = 1'b0;
      stack_wdata  = '0;
      clear_i      = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      irq_ack      = 1'b0;
      ack_vector   = '0;
      case (r_state)
         S_PUSH_LO: begin
            stall       = 1'b1;
            stack_we    = 1'b1;
            stack_wdata = w_ret_lo;
            clear_i     = 1'b1;
            irq_ack     = 1'b1;
            ack_vector  = r_vec;
         end
         S_PUSH_HI: begin
            stall       = 1'b1;
            stack_we    = 1'b1;
            stack_wdata = w_ret_hi;
         end
         S_JUMP: begin
            stall        = 1'b1;
            pc_load      = 1'b1;
            pc_load_addr = r_vec;
         end
         default: begin
         end
      endcase
   end

   assign busy = ~w_idle;

endmodule

// File: tb/tb_irq_sequencer.sv
// ----------------------------------------------------------------------------
// tb_irq_sequencer
//
// Directed bench for irq_sequencer with hand-computed expectations. Inputs
// change 1 time unit after a rising edge; outputs are sampled at that point,
// i.e. after the state has settled following the edge.
// ----------------------------------------------------------------------------
module tb_irq_sequencer;

   localparam int DW = 8;
   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic          irq_req;
   logic [AW-1:0] irq_vector;
   logic          insn_boundary;
   logic [AW-1:0] pc_next;
   logic          reti_exec;
   logic          stall;
   logic          stack_we;
   logic [DW-1:0] stack_wdata;
   logic          clear_i;
   logic          pc_load;
   logic [AW-1:0] pc_load_addr;
   logic          irq_ack;
   logic [AW-1:0] ack_vector;
   logic          busy;

   int n_checks;
   int n_fail;

   irq_sequencer #(
      .DATA_WIDTH   (DW),
      .I_ADDR_WIDTH (AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .irq_req       (irq_req),
      .irq_vector    (irq_vector),
      .insn_boundary (insn_boundary),
      .pc_next       (pc_next),
      .reti_exec     (reti_exec),
      .stall         (stall),
      .stack_we      (stack_we),
      .stack_wdata   (stack_wdata),
      .clear_i       (clear_i),
      .pc_load       (pc_load),
      .pc_load_addr  (pc_load_addr),
      .irq_ack       (irq_ack),
      .ack_vector    (ack_vector),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse flags packed as {stall,busy,stack_we,clear_i,irq_ack,pc_load}.
   function automatic logic [15:0] flags();
      return 16'({stall, busy, stack_we, clear_i, irq_ack, pc_load});
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flags"}, flags(), 16'h0);
      chk({tag, "_wdata"}, 16'(stack_wdata), 16'h0);
      chk({tag, "_pcaddr"}, 16'(pc_load_addr), 16'h0);
      chk({tag, "_ackvec"}, 16'(ack_vector), 16'h0);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      irq_req       = 1'b0;
      irq_vector    = '0;
      insn_boundary = 1'b0;
      pc_next       = '0;
      reti_exec     = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Basic entry: vector 0x005, return 0x2A7.
      irq_req = 1'b1; irq_vector = 10'h005; pc_next = 10'h2A7; insn_boundary = 1'b1;
      #1;
      chk("basic_T_stall", 16'(stall), 16'h0);
      tick();
      irq_req = 1'b0; insn_boundary = 1'b0; irq_vector = '0; pc_next = '0;
      chk("basic_T1_flags", flags(), 16'b111110);
      chk("basic_T1_wdata", 16'(stack_wdata), 16'h0A7);
      chk("basic_T1_ackvec", 16'(ack_vector), 16'h005);
      tick();
      chk("basic_T2_flags", flags(), 16'b111000);
      chk("basic_T2_wdata", 16'(stack_wdata), 16'h002);
      chk("basic_T2_ackvec", 16'(ack_vector), 16'h000);
      tick();
      chk("basic_T3_flags", flags(), 16'b110001);
      chk("basic_T3_pcaddr", 16'(pc_load_addr), 16'h005);
      chk("basic_T3_wdata", 16'(stack_wdata), 16'h000);
      tick();
      chk_all_zero("basic_T4");

      // No boundary: request alone does nothing.
      irq_req = 1'b1; irq_vector = 10'h00A; pc_next = 10'h155;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("noboundary_idle", flags(), 16'h0);
      end
      insn_boundary = 1'b1;
      tick();
      insn_boundary = 1'b0; irq_req = 1'b0;
      chk("noboundary_start_flags", flags(), 16'b111110);
      chk("noboundary_start_wdata", 16'(stack_wdata), 16'h055);
      tick(); tick(); tick();
      chk("noboundary_done", flags(), 16'h0);

      // RETI guard.
      irq_req = 1'b1; irq_vector = 10'h004; pc_next = 10'h0C3;
      insn_boundary = 1'b1; reti_exec = 1'b1;
      tick();
      reti_exec = 1'b0; insn_boundary = 1'b0;
      chk("reti_same_cycle", flags(), 16'h0);
      tick(); tick();
      chk("reti_wait", flags(), 16'h0);
      insn_boundary = 1'b1;
      tick();
      insn_boundary = 1'b0;
      chk("reti_first_boundary", flags(), 16'h0);
      tick();
      chk("reti_between", flags(), 16'h0);
      insn_boundary = 1'b1;
      tick();
      insn_boundary = 1'b0; irq_req = 1'b0;
      chk("reti_second_boundary", flags(), 16'b111110);
      chk("reti_second_ackvec", 16'(ack_vector), 16'h004);
      tick(); tick(); tick();
      chk("reti_done", flags(), 16'h0);

      // Vector capture: inputs change after accept.
      irq_req = 1'b1; irq_vector = 10'h003; pc_next = 10'h100; insn_boundary = 1'b1;
      tick();
      irq_vector = 10'h001; irq_req = 1'b0; insn_boundary = 1'b0; pc_next = 10'h3FF;
      chk("capture_ackvec", 16'(ack_vector), 16'h003);
      chk("capture_lo", 16'(stack_wdata), 16'h000);
      tick();
      chk("capture_hi", 16'(stack_wdata), 16'h001);
      tick();
      chk("capture_pcaddr", 16'(pc_load_addr), 16'h003);
      tick();

      // Reset mid-sequence during PUSH_HI.
      irq_req = 1'b1; irq_vector = 10'h006; pc_next = 10'h2BC; insn_boundary = 1'b1;
      tick();
      irq_req = 1'b0; insn_boundary = 1'b0;
      tick();
      chk("midreset_pushhi", flags(), 16'b111000);
      reset = 1'b1;
      #1;
      chk_all_zero("midreset_async");
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midreset_after", flags(), 16'h0);
      end
      irq_req = 1'b1; irq_vector = 10'h007; pc_next = 10'h123; insn_boundary = 1'b1;
      tick();
      irq_req = 1'b0; insn_boundary = 1'b0;
      chk("midreset_new_lo", 16'(stack_wdata), 16'h023);
      tick();
      chk("midreset_new_hi", 16'(stack_wdata), 16'h001);
      tick();
      chk("midreset_new_pcaddr", 16'(pc_load_addr), 16'h007);
      tick();

      // Maximum PC, with request and boundary held high throughout to check
      // back-to-back re-entry at T+4.
      irq_req = 1'b1; irq_vector = 10'h010; pc_next = 10'h3FF; insn_boundary = 1'b1;
      tick();
      pc_next = 10'h001;
      chk("maxpc_lo", 16'(stack_wdata), 16'h0FF);
      tick();
      chk("maxpc_hi", 16'(stack_wdata), 16'h003);
      tick();
      chk("maxpc_jump", flags(), 16'b110001);
      tick();
      chk("b2b_T4_idle", flags(), 16'h0);
      tick();
      irq_req = 1'b0; insn_boundary = 1'b0;
      chk("b2b_reentry_flags", flags(), 16'b111110);
      chk("b2b_reentry_lo", 16'(stack_wdata), 16'h001);
      tick(); tick(); tick();
      chk("b2b_done", flags(), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt entry sequencer for the ATtiny20 core. It sits between the interrupt controller's registered request/vector outputs and the core's fetch/stack logic. At an instruction boundary it accepts a pending request, stalls the core, and pushes the return address onto the stack as two bytes. It then clears the global interrupt flag and loads the PC with the interrupt vector. It also enforces the AVR rule that one instruction executes after RETI before another interrupt is taken.

## Interface
Parameters:
- DATA_WIDTH, 8, stack data width.
- I_ADDR_WIDTH, 10, program counter width; legal range 9..16.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- irq_req  in  1  pending, enabled interrupt from the interrupt controller.
- irq_vector  in  I_ADDR_WIDTH  vector address paired with irq_req.
- insn_boundary  in  1  high on the last cycle of the instruction currently retiring.
- pc_next  in  I_ADDR_WIDTH  return address: the address of the next instruction to execute.
- reti_exec  in  1  one-cycle pulse on the retiring cycle of RETI; coincides with insn_boundary.
- stall  out  1  core must hold fetch and execute.
- stack_we  out  1  one stack write; the core writes stack_wdata at SP, then decrements SP.
- stack_wdata  out  DATA_WIDTH  byte to push.
- clear_i  out  1  one-cycle pulse; the core clears SREG.I.
- pc_load  out  1  one-cycle pulse; the core loads the PC.
- pc_load_addr  out  I_ADDR_WIDTH  PC value to load.
- irq_ack  out  1  one-cycle pulse; the peripheral clears the flag for ack_vector.
- ack_vector  out  I_ADDR_WIDTH  vector being acknowledged.
- busy  out  1  sequence in progress (state not IDLE).

## Operation
- **States.** IDLE, PUSH_LO, PUSH_HI, JUMP. One state register; all outputs are decoded from the state and the captured registers.
- **Accept condition.** accept = IDLE & insn_boundary & irq_req & ~reti_block & ~reti_exec.
- **On accept.** Capture irq_vector into vec_q and pc_next into ret_q, then go to PUSH_LO.
  - Changes on irq_req or irq_vector after accept are ignored; vec_q is used.
- **PUSH_LO.**
  - stall=1, stack_we=1, stack_wdata=ret_q[7:0].
  - clear_i=1, irq_ack=1, ack_vector=vec_q.
  - Next state: PUSH_HI.
- **PUSH_HI.**
  - stall=1, stack_we=1.
  - stack_wdata = ret_q[I_ADDR_WIDTH-1:8], zero-extended to DATA_WIDTH.
  - Next state: JUMP.
- **JUMP.** stall=1, pc_load=1, pc_load_addr=vec_q. Next state: IDLE.
- **IDLE outputs.** All outputs are 0, including stack_wdata, pc_load_addr and ack_vector.
- **reti_block flag.**
  - Set when reti_exec=1, in any state.
  - Otherwise cleared on a cycle with IDLE & insn_boundary.
  - Result: the instruction following RETI always retires before any interrupt is accepted.
- **insn_boundary outside IDLE.** Ignored; the core does not assert it while stalled.
- **Simultaneous events.** reti_exec together with insn_boundary and irq_req: no accept; reti_block is set.
- **Reset.**
  - Asynchronous; state goes to IDLE.
  - reti_block, vec_q and ret_q go to 0.
  - Every output goes to 0.
  - A reset mid-sequence abandons it immediately: no further stack writes, no pc_load.

## Timing
- **Cycle T, accept.** stall is still 0; the boundary instruction retires normally.
- **T+1, PUSH_LO.** Low byte pushed; clear_i and irq_ack pulse.
- **T+2, PUSH_HI.** High byte pushed.
- **T+3, JUMP.** pc_load with vec_q.
- **T+4.** IDLE; the core fetches from the vector.
  - Earliest next accept is T+4, and only if insn_boundary is high.
- **Overall.** stall is high for exactly 3 cycles (T+1..T+3), and busy equals stall.
- **Pulse widths.** Each of stack_we, clear_i, irq_ack and pc_load is high for the stated cycles only, with no glitches from inputs.
- **Back-to-back requests.** irq_req held high continuously is taken once per sequence. Re-entry requires a new boundary in IDLE with reti_block clear.

## Test plan
- **Basic entry.** Reset, then irq_req=1, irq_vector=0x005, pc_next=0x2A7, insn_boundary=1 at T.
  - T+1: stack_we=1, stack_wdata=0xA7, clear_i=1, irq_ack=1, ack_vector=0x005.
  - T+2: stack_wdata=0x02.
  - T+3: pc_load=1, pc_load_addr=0x005.
  - T+4: stall=0.
- **No boundary.** irq_req=1 with insn_boundary=0 for 10 cycles: stall=0 and no outputs asserted. Assert insn_boundary: sequence starts on the next cycle.
- **RETI guard.** reti_exec=1 with insn_boundary=1 and irq_req=1: no accept. At the next boundary: still no accept. At the second boundary after RETI: accept, with stack_we at +1.
- **Vector capture.** Change irq_vector from 0x003 to 0x001 and drop irq_req at T+1: pc_load_addr=0x003 at T+3.
- **Reset mid-sequence.** Assert reset during PUSH_HI:
  - All outputs 0 immediately.
  - After release: state IDLE and no pc_load.
  - A new request is accepted normally.
- **Maximum PC.** pc_next=0x3FF with I_ADDR_WIDTH=10: pushes are 0xFF then 0x03.
